page_pattern_scanner: RTL

- Parametrised successor to the fixed 288-bit, 4-pattern page matcher.
- Scans one block of pages per comparison epoch against up to NPAT page-size patterns, with per-pattern enables.
- Streams matching global page numbers out one per valid/ready handshake, in ascending order, instead of producing a packed array.
- Sits between the bloom-filter array buffer and the FTL lookup logic.

---
 rtl/page_pattern_scanner.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/page_pattern_scanner.sv
// Scans NOB blocks of PPB pages against NPAT enabled patterns and streams matching page numbers in ascending order.
// Latency: one CMP cycle per block plus one cycle per hit. The design holds tpn/tpn_valid while tpn_ready is low.
// Optional PATTERN_MASK_EN adds a pat_mask input; a 0 mask bit means don't-care for that pattern bit.
module page_pattern_scanner #(
    parameter int P_SIZE = 12,
    parameter int PPB    = 8,
    parameter int NOB    = 3,
    parameter int NPAT   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [NOB*PPB*P_SIZE-1:0]         a,
    input  logic [NPAT*P_SIZE-1:0]            pats,
`ifdef PATTERN_MASK_EN
    input  logic [NPAT*P_SIZE-1:0]            pat_mask,
`endif
    input  logic [NPAT-1:0]                   pat_en,
    output logic                              busy,
    output logic                              tpn_valid,
    input  logic                              tpn_ready,
    output logic [$clog2(NOB*PPB)-1:0]        tpn,
    output logic                              done,
    output logic [$clog2(NOB*PPB+1)-1:0]      match_cnt
);
    localparam int NOP   = NOB * PPB;
    localparam int NOP_W = $clog2(NOP);
    localparam int CNT_W = $clog2(NOP + 1);
    localparam int B_W   = (NOB > 1) ? $clog2(NOB) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CMP, S_EMIT, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [NOP*P_SIZE-1:0]    a_q, a_d;
    logic [NPAT*P_SIZE-1:0]   pats_q, pats_d;
    logic [NPAT*P_SIZE-1:0]   mask_eff;
    logic [NPAT-1:0]          en_q, en_d;
    logic [B_W-1:0]           blk_q, blk_d;
    logic [PPB-1:0]           hit_q, hit_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [PPB*P_SIZE-1:0]    blk_pages;
    logic [PPB-1:0]           cmp_hit;
    logic [PPB-1:0]           low_oh;
    logic [NOP_W-1:0]         low_idx;
    logic [NOP_W-1:0]         base;
    logic                     last_blk;
    logic                     last_bit;

`ifdef PATTERN_MASK_EN
    logic [NPAT*P_SIZE-1:0]   mask_q, mask_d;
    assign mask_eff = mask_q;
`else
    assign mask_eff = '1;
`endif

    assign blk_pages = a_q[int'(blk_q)*PPB*P_SIZE +: PPB*P_SIZE];

    // A page hits once no matter how many enabled patterns it matches.
    always_comb begin
        cmp_hit = '0;
        for (int k = 0; k < PPB; k++) begin
            for (int j = 0; j < NPAT; j++) begin
                if (en_q[j] && (((blk_pages[k*P_SIZE +: P_SIZE] ^ pats_q[j*P_SIZE +: P_SIZE])
                                 & mask_eff[j*P_SIZE +: P_SIZE]) == '0))
                    cmp_hit[k] = 1'b1;
            end
        end
    end

    always_comb begin
        low_idx = '0;
        low_oh  = '0;
        for (int k = PPB - 1; k >= 0; k--) begin
            if (hit_q[k]) begin
                low_idx   = NOP_W'(k);
                low_oh    = '0;
                low_oh[k] = 1'b1;
            end
        end
    end

    assign base     = NOP_W'(blk_q) * NOP_W'(PPB);
    assign last_blk = (blk_q == B_W'(NOB - 1));
    assign last_bit = ((hit_q & ~low_oh) == '0);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        pats_d  = pats_q;
        en_d    = en_q;
        blk_d   = blk_q;
        hit_d   = hit_q;
        cnt_d   = cnt_q;
`ifdef PATTERN_MASK_EN
        mask_d  = mask_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    pats_d  = pats;
                    en_d    = pat_en;
`ifdef PATTERN_MASK_EN
                    mask_d  = pat_mask;
`endif
                    blk_d   = '0;
                    hit_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                hit_d = cmp_hit;
                if (|cmp_hit)
                    state_d = S_EMIT;
                else if (last_blk)
                    state_d = S_DONE;
                else
                    blk_d = blk_q + 1'b1;
            end
            S_EMIT: begin
                if (tpn_ready) begin
                    hit_d = hit_q & ~low_oh;
                    cnt_d = cnt_q + 1'b1;
                    if (last_bit) begin
                        if (last_blk) begin
                            state_d = S_DONE;
                        end else begin
                            blk_d   = blk_q + 1'b1;
                            state_d = S_CMP;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            pats_q  <= '0;
            en_q    <= '0;
            blk_q   <= '0;
            hit_q   <= '0;
            cnt_q   <= '0;
`ifdef PATTERN_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            pats_q  <= pats_d;
            en_q    <= en_d;
            blk_q   <= blk_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
`ifdef PATTERN_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign busy      = (state_q == S_CMP) || (state_q == S_EMIT);
    assign tpn_valid = (state_q == S_EMIT);
    assign tpn       = (state_q == S_EMIT) ? (base + low_idx) : '0;
    assign done      = (state_q == S_DONE);
    assign match_cnt = cnt_q;
endmodule
